// File: rtl/systolic_operand_feeder_pkg.sv
// systolic_operand_feeder_pkg: shared FSM state encoding for the operand feeder
package systolic_operand_feeder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: DEPTH-stage synchronous-reset shift register for one operand lane
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [DEPTH-1:0][WIDTH-1:0] sr_q;
  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end
  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/systolic_operand_feeder.sv
// systolic_operand_feeder: accepts A/B beats, applies diagonal skew, flushes zeros and pulses done
module systolic_operand_feeder
  import systolic_operand_feeder_pkg::*;
#(
  parameter int ROWS      = 32,
  parameter int COLS      = 32,
  parameter int WORD_SIZE = 16,
  parameter int KW        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [KW-1:0]             k_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS*WORD_SIZE-1:0] a_vec_in,
  input  logic [COLS*WORD_SIZE-1:0] b_vec_in,
  output logic [ROWS*WORD_SIZE-1:0] left_in_bus,
  output logic [COLS*WORD_SIZE-1:0] top_in_bus,
  output logic                      busy,
  output logic                      done
);
  localparam int FW = $clog2(ROWS + COLS);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS + COLS - 2);
  state_t state_q, state_d;
  logic [KW-1:0] klen_q, klen_d, beat_q, beat_d;
  logic [FW-1:0] flush_q, flush_d;
  logic fire, last_beat, last_flush;
  logic [ROWS*WORD_SIZE-1:0] a_inj;
  logic [COLS*WORD_SIZE-1:0] b_inj;
  assign in_ready   = state_q == STREAM;
  assign busy       = state_q == STREAM || state_q == FLUSH;
  assign done       = state_q == DONE;
  assign fire       = in_valid && in_ready;
  assign last_beat  = beat_q == klen_q - KW'(1);
  assign last_flush = flush_q == FLUSH_LAST;
  // the array has no enable, so every non-fire cycle must inject an all-zero beat
  assign a_inj = fire ? a_vec_in : '0;
  assign b_inj = fire ? b_vec_in : '0;
  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    case (state_q)
      IDLE: if (start) begin
        klen_d  = k_len;
        state_d = (k_len == '0) ? DONE : STREAM;
      end
      STREAM: if (fire) begin
        beat_d  = last_beat ? '0 : beat_q + KW'(1);
        state_d = last_beat ? FLUSH : STREAM;
      end
      FLUSH: begin
        flush_d = last_flush ? '0 : flush_q + FW'(1);
        state_d = last_flush ? DONE : FLUSH;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      klen_q  <= '0;
      beat_q  <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
    end
  end
  for (genvar r = 0; r < ROWS; r++) begin : g_a
    skew_delay_line #(.DEPTH(r + 1), .WIDTH(WORD_SIZE)) u_dl (
      .clk (clk),
      .rst (rst),
      .d_i (a_inj[(r+1)*WORD_SIZE-1 -: WORD_SIZE]),
      .q_o (left_in_bus[(r+1)*WORD_SIZE-1 -: WORD_SIZE])
    );
  end
  for (genvar c = 0; c < COLS; c++) begin : g_b
    skew_delay_line #(.DEPTH(c + 1), .WIDTH(WORD_SIZE)) u_dl (
      .clk (clk),
      .rst (rst),
      .d_i (b_inj[(c+1)*WORD_SIZE-1 -: WORD_SIZE]),
      .q_o (top_in_bus[(c+1)*WORD_SIZE-1 -: WORD_SIZE])
    );
  end
endmodule

// File: tb/tb_systolic_operand_feeder.sv
// tb_systolic_operand_feeder: directed checks of skew timing, bubbles, flush length, done and reset
module tb_systolic_operand_feeder;
  localparam int R = 4, C = 4, W = 16, KW = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic in_ready, busy, done;
  logic [KW-1:0] k_len = '0;
  logic [R*W-1:0] a_vec_in = '0, left_in_bus;
  logic [C*W-1:0] b_vec_in = '0, top_in_bus;
  int checks = 0, errors = 0, cyc = 0, zb = 0;
  logic [63:0] ah [0:4095];
  logic [63:0] bh [0:4095];

  systolic_operand_feeder #(.ROWS(R), .COLS(C), .WORD_SIZE(W), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_ready(in_ready), .a_vec_in(a_vec_in), .b_vec_in(b_vec_in),
    .left_in_bus(left_in_bus), .top_in_bus(top_in_bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // lane r at sample cyc carries what was injected r+1 cycles earlier, zero before a reset
  function automatic logic [63:0] skew(input bit sel_b);
    logic [63:0] v = '0;
    for (int r = 0; r < 4; r++) begin
      int i = cyc - 1 - r;
      if (i >= zb) v[r*16 +: 16] = sel_b ? bh[i][r*16 +: 16] : ah[i][r*16 +: 16];
    end
    return v;
  endfunction

  task automatic chk_bus(input string tag);
    chk({tag, "_left"}, left_in_bus, skew(1'b0));
    chk({tag, "_top"}, top_in_bus, skew(1'b1));
  endtask

  task automatic tick(input bit f);
    bit r_now = rst;
    ah[cyc] = f ? a_vec_in : '0;
    bh[cyc] = f ? b_vec_in : '0;
    @(posedge clk);
    #1;
    cyc++;
    if (r_now) zb = cyc;
  endtask

  initial begin
    tick(0); tick(0);
    rst = 1'b0;
    // 1: idle after reset
    for (int n = 0; n < 5; n++) begin
      tick(0);
      chk("idle_left", left_in_bus, 64'h0);
      chk("idle_top", top_in_bus, 64'h0);
      chk1("idle_ready", in_ready, 1'b0);
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_done", done, 1'b0);
    end
    // 2: single beat, k_len=1
    start = 1'b1; k_len = 8'd1;
    tick(0);
    start = 1'b0;
    chk1("t2_ready", in_ready, 1'b1);
    chk1("t2_busy", busy, 1'b1);
    a_vec_in = 64'h0004_0003_0002_0001; b_vec_in = 64'h0008_0007_0006_0005; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0; a_vec_in = '0; b_vec_in = '0;
    for (int n = 1; n <= 10; n++) begin
      chk_bus("t2");
      if (n == 1) chk("t2_left_n1", left_in_bus, 64'h0000_0000_0000_0001);
      if (n == 3) chk("t2_top_n3", top_in_bus, 64'h0000_0007_0000_0000);
      if (n == 4) chk("t2_left_n4", left_in_bus, 64'h0004_0000_0000_0000);
      chk1("t2_done", done, n == 8);
      chk1("t2_ready_flush", in_ready, 1'b0);
      chk1("t2_busy_flush", busy, n < 8);
      tick(0);
    end
    // 3: k_len=3 with two bubbles between beats 1 and 2
    start = 1'b1; k_len = 8'd3;
    tick(0);
    start = 1'b0;
    a_vec_in = 64'h0004_0003_0002_0001; b_vec_in = 64'h0008_0007_0006_0005; in_valid = 1'b1;
    tick(1);
    chk_bus("t3_b1");
    in_valid = 1'b0;
    tick(0);
    chk_bus("t3_bub1");
    chk("t3_left_bubble", left_in_bus, 64'h0000_0000_0002_0000);
    chk1("t3_ready_bub", in_ready, 1'b1);
    tick(0);
    chk_bus("t3_bub2");
    a_vec_in = 64'h1111_2222_3333_4444; b_vec_in = 64'h5555_6666_7777_8888; in_valid = 1'b1;
    tick(1);
    chk_bus("t3_b2");
    chk("t3_left_b2", left_in_bus, 64'h0004_0000_0000_4444);
    a_vec_in = 64'h000D_000C_000B_000A; b_vec_in = 64'h00F0_00E0_00D0_00C0;
    tick(1);
    in_valid = 1'b0; a_vec_in = '0; b_vec_in = '0;
    for (int n = 1; n <= 9; n++) begin
      chk_bus("t3_flush");
      chk1("t3_done", done, n == 8);
      tick(0);
    end
    // 4: k_len=0 completes immediately, never accepts
    start = 1'b1; k_len = 8'd0; in_valid = 1'b1; a_vec_in = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(0);
    start = 1'b0;
    chk1("t4_done", done, 1'b1);
    chk1("t4_ready", in_ready, 1'b0);
    chk1("t4_busy", busy, 1'b0);
    tick(0);
    chk1("t4_done_off", done, 1'b0);
    chk1("t4_ready2", in_ready, 1'b0);
    chk("t4_left", left_in_bus, 64'h0);
    chk("t4_top", top_in_bus, 64'h0);
    in_valid = 1'b0; a_vec_in = '0;
    // 5: start during STREAM with a different k_len is ignored
    start = 1'b1; k_len = 8'd2;
    tick(0);
    start = 1'b0;
    a_vec_in = 64'h0001_0001_0001_0001; b_vec_in = 64'h0002_0002_0002_0002; in_valid = 1'b1;
    tick(1);
    start = 1'b1; k_len = 8'd5;
    chk1("t5_ready_mid", in_ready, 1'b1);
    tick(1);
    start = 1'b0; in_valid = 1'b0; a_vec_in = '0; b_vec_in = '0;
    chk1("t5_ready_end", in_ready, 1'b0);
    chk1("t5_busy_flush", busy, 1'b1);
    for (int n = 1; n <= 8; n++) begin
      chk_bus("t5_flush");
      chk1("t5_done", done, n == 8);
      tick(0);
    end
    // 6: reset after 2 of 5 beats, then a fresh job
    start = 1'b1; k_len = 8'd5;
    tick(0);
    start = 1'b0;
    a_vec_in = 64'h0009_0009_0009_0009; b_vec_in = 64'h0003_0003_0003_0003; in_valid = 1'b1;
    tick(1); tick(1);
    chk("t6_left_pre", left_in_bus, 64'h0000_0000_0009_0009);
    rst = 1'b1;
    tick(0);
    rst = 1'b0; in_valid = 1'b0; a_vec_in = '0; b_vec_in = '0;
    chk1("t6_busy_rst", busy, 1'b0);
    chk1("t6_ready_rst", in_ready, 1'b0);
    chk("t6_left_rst", left_in_bus, 64'h0);
    chk("t6_top_rst", top_in_bus, 64'h0);
    for (int n = 0; n < 10; n++) begin
      tick(0);
      chk1("t6_no_done", done, 1'b0);
      chk_bus("t6_idle");
    end
    start = 1'b1; k_len = 8'd1;
    tick(0);
    start = 1'b0;
    a_vec_in = 64'h00AA_00BB_00CC_00DD; b_vec_in = 64'h0011_0022_0033_0044; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0; a_vec_in = '0; b_vec_in = '0;
    for (int n = 1; n <= 8; n++) begin
      chk_bus("t6_new");
      if (n == 2) chk("t6_left_n2", left_in_bus, 64'h0000_0000_00CC_0000);
      chk1("t6_new_done", done, n == 8);
      tick(0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
